// File: rtl/vc_crossbar_pkg.sv
// Shared types for the VC crossbar: flit layout, lock state encoding, default head reserve.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
//
// Package switch_pkg
//   flit_t        : vc / head / tail / payload, packed MSB-first in that order
//   lock_state_e  : per-output wormhole lock state
//   credit_ok()   : head/body credit admission rule shared by every output
package switch_pkg;

  localparam int VC_W                 = 1;   // wide enough for the default two VCs
  localparam int PAYLOAD_W            = 16;
  localparam int DEFAULT_HEAD_RESERVE = 2;

  typedef struct packed {
    logic [VC_W-1:0]      vc;
    logic                 head;
    logic                 tail;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // A head flit must leave HEAD_RESERVE slots free downstream so packets
  // already in flight can always finish; body/tail flits need one slot.
  function automatic logic credit_ok(input logic head, input int cnt, input int reserve);
    return head ? (cnt > reserve) : (cnt >= 1);
  endfunction

endpackage

// File: rtl/vc_crossbar_credit_counter.sv
// Saturating per-output, per-VC credit counter; resets full (BUFFER_SIZE credits).
// Latency: count updates on the clock edge after dec/inc are presented.
// Backpressure: none; callers never decrement an empty counter, clamping is only a safety net.
//
// Ports
//   clk, rst : clock, asynchronous active-high reset
//   dec      : one credit consumed this cycle (flit loaded on this VC)
//   inc      : credit-return pulse, adds CREDIT_INC
//   count    : current credit count
module credit_counter
  import switch_pkg::*;
#(
  parameter  int BUFFER_SIZE = 8,
  parameter  int CREDIT_INC  = 1,
  localparam int CNT_W       = $clog2(BUFFER_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  int               sum;
  logic [CNT_W-1:0] count_d;

  // Signed arithmetic so a simultaneous decrement and grant net out and the
  // result can be clamped to [0, BUFFER_SIZE] before narrowing.
  always_comb begin
    sum = int'(count) - (dec ? 1 : 0) + (inc ? CREDIT_INC : 0);
    if (sum > BUFFER_SIZE) begin
      sum = BUFFER_SIZE;
    end else if (sum < 0) begin
      sum = 0;
    end
    count_d = CNT_W'(sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= CNT_W'(BUFFER_SIZE);
    end else begin
      count <= count_d;
    end
  end

endmodule

// File: rtl/vc_crossbar.sv
// Registered NUM_IN x NUM_OUT crossbar with wormhole locking and per-output, per-VC credits.
// Latency: 1 cycle input->output; full-rate back-to-back loads when out_ready stays high.
// Backpressure: out_ready low holds the registered flit (never dropped); credits are taken at load.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   in_flit/in_valid: head flit of each input buffer and its valid
//   in_pop          : combinational, input i's flit is consumed this cycle (0 while rst)
//   sel             : allocator-chosen source per output, ignored while that output is locked;
//                     a value >= NUM_IN selects no source
//   enable          : output may accept a new flit
//   out_flit/out_valid/out_ready : registered output with valid/ready handshake
//   credit_granted  : one-cycle credit-return pulse per output x VC
//   credit_count    : current credits per output x VC
//   locked          : output is mid-packet
module vc_crossbar
  import switch_pkg::*;
#(
  parameter  int NUM_IN       = 5,
  parameter  int NUM_OUT      = 5,
  parameter  int NUM_VCS      = 2,
  parameter  int BUFFER_SIZE  = 8,
  parameter  int HEAD_RESERVE = DEFAULT_HEAD_RESERVE,
  parameter  int CREDIT_INC   = 1,
  localparam int SEL_W        = $clog2(NUM_IN),
  localparam int CNT_W        = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  flit_t [NUM_IN-1:0]                       in_flit,
  input  logic  [NUM_IN-1:0]                       in_valid,
  output logic  [NUM_IN-1:0]                       in_pop,
  input  logic  [NUM_OUT-1:0][SEL_W-1:0]           sel,
  input  logic  [NUM_OUT-1:0]                      enable,
  output flit_t [NUM_OUT-1:0]                      out_flit,
  output logic  [NUM_OUT-1:0]                      out_valid,
  input  logic  [NUM_OUT-1:0]                      out_ready,
  input  logic  [NUM_OUT-1:0][NUM_VCS-1:0]         credit_granted,
  output logic  [NUM_OUT-1:0][NUM_VCS-1:0][CNT_W-1:0] credit_count,
  output logic  [NUM_OUT-1:0]                      locked
);

  lock_state_e                       state_q [NUM_OUT];
  lock_state_e                       state_d [NUM_OUT];
  logic        [NUM_OUT-1:0][SEL_W-1:0] lock_src_q;

  logic        [NUM_OUT-1:0][SEL_W-1:0] src;
  logic        [NUM_OUT-1:0]            src_ok;
  flit_t       [NUM_OUT-1:0]            cand;
  logic        [NUM_OUT-1:0]            req;
  logic        [NUM_OUT-1:0]            grant;
  logic        [NUM_IN-1:0]             claimed;
  logic        [NUM_IN-1:0]             taken;
  logic        [NUM_OUT-1:0][NUM_VCS-1:0] dec;

  // ------------------------------------------------------------------
  // Per-output candidate: locked outputs keep drawing from their packet's
  // input, otherwise follow the allocator. req covers everything except
  // contention with other outputs.
  // ------------------------------------------------------------------
  always_comb begin
    src    = '0;
    src_ok = '0;
    cand   = '0;
    req    = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      src[o]    = (state_q[o] == LOCKED) ? lock_src_q[o] : sel[o];
      src_ok[o] = int'(src[o]) < NUM_IN;
      if (src_ok[o]) begin
        cand[o] = in_flit[src[o]];
        req[o]  = !rst
                  && (!out_valid[o] || out_ready[o])
                  && enable[o]
                  && in_valid[src[o]]
                  && (int'(cand[o].vc) < NUM_VCS)
                  && credit_ok(cand[o].head,
                               int'(credit_count[o][cand[o].vc]),
                               HEAD_RESERVE);
      end
    end
  end

  // ------------------------------------------------------------------
  // Input-conflict resolution. An input owned by a locked output is reserved
  // for that output even on cycles it cannot load, otherwise another output
  // could steal the next flit of a packet in flight. Among unlocked outputs
  // the lowest index wins. taken guarantees a single pop per input.
  // ------------------------------------------------------------------
  always_comb begin
    claimed = '0;
    taken   = '0;
    grant   = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      if (state_q[o] == LOCKED) begin
        claimed[lock_src_q[o]] = 1'b1;
      end
    end
    for (int o = 0; o < NUM_OUT; o++) begin
      if (state_q[o] == LOCKED && req[o]) begin
        grant[o]          = 1'b1;
        taken[lock_src_q[o]] = 1'b1;
      end
    end
    for (int o = 0; o < NUM_OUT; o++) begin
      if (state_q[o] == UNLOCKED && req[o]
          && !claimed[src[o]] && !taken[src[o]]) begin
        grant[o]      = 1'b1;
        taken[src[o]] = 1'b1;
      end
    end
    in_pop = taken;
  end

  // Credit consumed on the VC of the flit being loaded.
  always_comb begin
    dec = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        dec[o][v] = grant[o] && (int'(cand[o].vc) == v);
      end
    end
  end

  // ------------------------------------------------------------------
  // Lock FSM: a head without tail opens a packet, any tail closes it.
  // A single-flit packet (head+tail) leaves the output unlocked.
  // ------------------------------------------------------------------
  always_comb begin
    for (int o = 0; o < NUM_OUT; o++) begin
      state_d[o] = state_q[o];
      if (grant[o]) begin
        if (cand[o].tail) begin
          state_d[o] = UNLOCKED;
        end else if (cand[o].head) begin
          state_d[o] = LOCKED;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < NUM_OUT; o++) begin
        state_q[o] <= UNLOCKED;
      end
    end else begin
      for (int o = 0; o < NUM_OUT; o++) begin
        state_q[o] <= state_d[o];
      end
    end
  end

  always_comb begin
    locked = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      locked[o] = (state_q[o] == LOCKED);
    end
  end

  // ------------------------------------------------------------------
  // Output register and lock source. A load overrides the drain so a
  // flit accepted downstream can be replaced in the same cycle.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_flit   <= '0;
      out_valid  <= '0;
      lock_src_q <= '0;
    end else begin
      for (int o = 0; o < NUM_OUT; o++) begin
        if (grant[o]) begin
          out_flit[o]  <= cand[o];
          out_valid[o] <= 1'b1;
          if (cand[o].head && !cand[o].tail) begin
            lock_src_q[o] <= src[o];
          end
        end else if (out_valid[o] && out_ready[o]) begin
          out_valid[o] <= 1'b0;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Credit counters, one per output x VC.
  // ------------------------------------------------------------------
  for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
      credit_counter #(
        .BUFFER_SIZE (BUFFER_SIZE),
        .CREDIT_INC  (CREDIT_INC)
      ) u_credit (
        .clk   (clk),
        .rst   (rst),
        .dec   (dec[o][v]),
        .inc   (credit_granted[o][v]),
        .count (credit_count[o][v])
      );
    end
  end

endmodule

// File: tb/tb_vc_crossbar.sv
// Directed bench for vc_crossbar with a flit scoreboard on the output handshake.
// Latency: n/a.
// Backpressure: exercised through out_ready/enable steps.
module tb_vc_crossbar;
  import switch_pkg::*;

  localparam int NI = 5;
  localparam int NO = 5;
  localparam int NV = 2;
  localparam int SW = 3;
  localparam int CW = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  flit_t [NI-1:0]             in_flit;
  logic  [NI-1:0]             in_valid;
  logic  [NI-1:0]             in_pop;
  logic  [NO-1:0][SW-1:0]     sel;
  logic  [NO-1:0]             enable;
  flit_t [NO-1:0]             out_flit;
  logic  [NO-1:0]             out_valid;
  logic  [NO-1:0]             out_ready;
  logic  [NO-1:0][NV-1:0]     credit_granted;
  logic  [NO-1:0][NV-1:0][CW-1:0] credit_count;
  logic  [NO-1:0]             locked;

  typedef struct {
    int    o;
    flit_t f;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  vc_crossbar dut (
    .clk            (clk),
    .rst            (rst),
    .in_flit        (in_flit),
    .in_valid       (in_valid),
    .in_pop         (in_pop),
    .sel            (sel),
    .enable         (enable),
    .out_flit       (out_flit),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .credit_granted (credit_granted),
    .credit_count   (credit_count),
    .locked         (locked)
  );

  always #5 clk = ~clk;

  function automatic flit_t mk(input logic vc, input logic h, input logic t, input logic [15:0] p);
    flit_t f;
    f.vc      = vc;
    f.head    = h;
    f.tail    = t;
    f.payload = p;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cred(input int o, input int v, input int exp);
    chk($sformatf("credit[%0d][%0d]", o, v), 32'(credit_count[o][v]), 32'(exp));
  endtask

  task automatic push(input int o, input flit_t f);
    exp_t e;
    e.o = o;
    e.f = f;
    exp_q.push_back(e);
  endtask

  // One clock cycle: inputs already driven; mid-cycle check of in_pop and
  // of every output handshake against the scoreboard, then advance to #1
  // after the next rising edge.
  task automatic step(input logic [NI-1:0] exp_pop, input string tag);
    exp_t e;
    #1;
    chk({tag, " in_pop"}, 32'(in_pop), 32'(exp_pop));
    for (int o = 0; o < NO; o++) begin
      if (out_valid[o] && out_ready[o]) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("%s unexpected flit out%0d", tag, o), 32'(out_flit[o]), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk({tag, " sb_port"}, 32'(o), 32'(e.o));
          chk({tag, " sb_flit"}, {13'd0, out_flit[o]}, {13'd0, e.f});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  flit_t fa, fh;

  initial begin
    rst            = 1'b1;
    in_flit        = '0;
    in_valid       = '0;
    sel            = {NO{3'd7}};
    enable         = '1;
    out_ready      = '1;
    credit_granted = '0;

    // ---- reset state; in_pop masked while rst is high ----
    in_valid[0] = 1'b1;
    sel[0]      = 3'd0;
    #2;
    chk("rst in_pop", 32'(in_pop), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst locked", 32'(locked), 32'd0);
    chk("rst out_flit0", {13'd0, out_flit[0]}, 32'd0);
    for (int o = 0; o < NO; o++)
      for (int v = 0; v < NV; v++) chk_cred(o, v, 8);
    in_valid = '0;
    sel[0]   = 3'd7;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ---- 1) single flit, input 2 -> output 1 ----
    fa         = mk(1'b0, 1'b1, 1'b1, 16'hA1);
    in_flit[2] = fa;
    in_valid   = 5'b00100;
    sel[1]     = 3'd2;
    push(1, fa);
    step(5'b00100, "t1_load");
    chk("t1 out_valid1", 32'(out_valid[1]), 32'd1);
    chk("t1 out_flit1", {13'd0, out_flit[1]}, {13'd0, fa});
    chk_cred(1, 0, 7);
    chk_cred(1, 1, 8);
    in_valid = '0;
    step(5'b00000, "t1_idle");
    chk("t1 out_valid1 drained", 32'(out_valid[1]), 32'd0);
    sel[1] = 3'd7;

    // ---- 2) 3-flit packet input 0 -> output 3, sel moves after head ----
    in_flit[0] = mk(1'b0, 1'b1, 1'b0, 16'hB0);
    in_valid   = 5'b00001;
    sel[3]     = 3'd0;
    push(3, in_flit[0]);
    step(5'b00001, "t2_head");
    chk("t2 locked after head", 32'(locked[3]), 32'd1);
    sel[3]     = 3'd4;
    in_flit[4] = mk(1'b1, 1'b1, 1'b1, 16'hBF);
    in_flit[0] = mk(1'b0, 1'b0, 1'b0, 16'hB1);
    in_valid   = 5'b10001;
    push(3, in_flit[0]);
    step(5'b00001, "t2_body");
    chk("t2 locked after body", 32'(locked[3]), 32'd1);
    in_flit[0] = mk(1'b0, 1'b0, 1'b1, 16'hB2);
    push(3, in_flit[0]);
    step(5'b00001, "t2_tail");
    chk("t2 unlocked after tail", 32'(locked[3]), 32'd0);
    chk_cred(3, 0, 5);
    chk_cred(3, 1, 8);
    in_valid = '0;
    sel[3]   = 3'd7;
    step(5'b00000, "t2_idle");

    // ---- 3) outputs 1 and 2 contend for input 4 ----
    fa         = mk(1'b1, 1'b1, 1'b1, 16'hC0);
    in_flit[4] = fa;
    in_valid   = 5'b10000;
    sel[1]     = 3'd4;
    sel[2]     = 3'd4;
    push(1, fa);
    step(5'b10000, "t3_low_wins");
    chk("t3 out_valid1", 32'(out_valid[1]), 32'd1);
    chk("t3 out_valid2", 32'(out_valid[2]), 32'd0);
    chk_cred(1, 1, 7);
    chk_cred(2, 1, 8);
    sel[1]     = 3'd7;
    in_flit[4] = mk(1'b1, 1'b1, 1'b0, 16'hC1);
    push(2, in_flit[4]);
    step(5'b10000, "t3_lock2");
    chk("t3 locked2", 32'(locked[2]), 32'd1);
    sel[1]     = 3'd4;
    in_flit[4] = mk(1'b1, 1'b0, 1'b1, 16'hC2);
    push(2, in_flit[4]);
    step(5'b10000, "t3_locked_wins");
    chk("t3 out1 stalled", 32'(out_valid[1]), 32'd0);
    chk("t3 locked2 released", 32'(locked[2]), 32'd0);
    chk_cred(2, 1, 6);
    chk_cred(1, 1, 7);
    in_valid = '0;
    sel[1]   = 3'd7;
    sel[2]   = 3'd7;
    step(5'b00000, "t3_idle");

    // ---- 4) credit rules on output 0, VC1, from input 1 ----
    in_valid = 5'b00010;
    sel[0]   = 3'd1;
    for (int k = 0; k < 6; k++) begin
      in_flit[1] = mk(1'b1, k == 0, k == 5, 16'(16'hD0 + k));
      push(0, in_flit[1]);
      step(5'b00010, "t4_fill");
    end
    chk_cred(0, 1, 2);
    chk("t4 unlocked after fill", 32'(locked[0]), 32'd0);
    fh         = mk(1'b1, 1'b1, 1'b0, 16'hD6);
    in_flit[1] = fh;
    step(5'b00000, "t4_head_stall");
    chk_cred(0, 1, 2);
    chk("t4 out_valid0 idle", 32'(out_valid[0]), 32'd0);
    credit_granted[0][1] = 1'b1;
    step(5'b00000, "t4_grant_stall");
    credit_granted[0][1] = 1'b0;
    chk_cred(0, 1, 3);
    push(0, fh);
    step(5'b00010, "t4_head_load");
    chk_cred(0, 1, 2);
    chk("t4 locked0", 32'(locked[0]), 32'd1);
    in_flit[1] = mk(1'b1, 1'b0, 1'b0, 16'hD7);
    push(0, in_flit[1]);
    step(5'b00010, "t4_body_at2");
    chk_cred(0, 1, 1);
    in_flit[1] = mk(1'b1, 1'b0, 1'b0, 16'hD8);
    push(0, in_flit[1]);
    step(5'b00010, "t4_body_at1");
    chk_cred(0, 1, 0);
    in_flit[1] = mk(1'b1, 1'b0, 1'b0, 16'hD9);
    step(5'b00000, "t4_body_stall");
    chk_cred(0, 1, 0);
    credit_granted[0][1] = 1'b1;
    step(5'b00000, "t4_grant_only");
    chk_cred(0, 1, 1);
    push(0, in_flit[1]);
    step(5'b00010, "t4_grant_and_load");
    credit_granted[0][1] = 1'b0;
    chk_cred(0, 1, 1);
    in_flit[1] = mk(1'b1, 1'b0, 1'b1, 16'hDA);
    push(0, in_flit[1]);
    step(5'b00010, "t4_tail");
    chk_cred(0, 1, 0);
    chk("t4 unlocked0", 32'(locked[0]), 32'd0);
    in_valid = '0;
    sel[0]   = 3'd7;
    step(5'b00000, "t4_idle");

    // ---- 5) output hold under out_ready=0, then drain with enable=0 ----
    fa           = mk(1'b0, 1'b1, 1'b1, 16'hE0);
    in_flit[2]   = fa;
    in_valid     = 5'b00100;
    sel[3]       = 3'd2;
    out_ready[3] = 1'b0;
    push(3, fa);
    step(5'b00100, "t5_load");
    in_flit[2] = mk(1'b0, 1'b1, 1'b1, 16'hE1);
    for (int k = 0; k < 4; k++) begin
      step(5'b00000, "t5_hold");
      chk("t5 held valid", 32'(out_valid[3]), 32'd1);
      chk("t5 held flit", {13'd0, out_flit[3]}, {13'd0, fa});
    end
    enable[3]    = 1'b0;
    out_ready[3] = 1'b1;
    step(5'b00000, "t5_drain");
    chk("t5 drained", 32'(out_valid[3]), 32'd0);
    step(5'b00000, "t5_no_reload");
    chk("t5 no reload", 32'(out_valid[3]), 32'd0);
    chk_cred(3, 0, 4);
    in_valid = '0;
    enable   = '1;
    sel[3]   = 3'd7;

    // ---- 6) reset mid-packet, then grants at full credit ----
    in_flit[3] = mk(1'b0, 1'b1, 1'b0, 16'hF0);
    in_valid   = 5'b01000;
    sel[4]     = 3'd3;
    push(4, in_flit[3]);
    step(5'b01000, "t6_head");
    chk("t6 locked4", 32'(locked[4]), 32'd1);
    chk_cred(4, 0, 7);
    in_flit[3] = mk(1'b0, 1'b0, 1'b0, 16'hF1);
    push(4, in_flit[3]);
    step(5'b01000, "t6_body");
    rst = 1'b1;
    #1;
    exp_q.delete();   // the body flit sitting in the output register is flushed
    chk("t6 rst out_valid", 32'(out_valid), 32'd0);
    chk("t6 rst locked", 32'(locked), 32'd0);
    chk("t6 rst in_pop", 32'(in_pop), 32'd0);
    chk("t6 rst out_flit4", {13'd0, out_flit[4]}, 32'd0);
    chk_cred(4, 0, 8);
    @(posedge clk);
    #1;
    rst            = 1'b0;
    in_valid       = '0;
    sel[4]         = 3'd7;
    credit_granted = '1;
    repeat (5) step(5'b00000, "t6_grant_sat");
    credit_granted = '0;
    for (int o = 0; o < NO; o++)
      for (int v = 0; v < NV; v++) chk_cred(o, v, 8);
    chk("t6 locked after reset", 32'(locked), 32'd0);
    chk("sb drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
